// File: rtl/matrix_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
// Shared definitions for the matrixMult result path: default matrix geometry,
// the serializer state encoding and the element-count helper.
// -----------------------------------------------------------------------------
package matrix_pkg;

  localparam int DSIZE  = 8;
  localparam int ROWS_A = 3;
  localparam int COLS_B = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  // Number of elements in a rowsA x colsB result matrix.
  function automatic int elem_count(input int rows, input int cols);
    return rows * cols;
  endfunction

  localparam int N = ROWS_A * COLS_B;

endpackage

// File: rtl/matrix_result_serializer.sv
// -----------------------------------------------------------------------------
// matrix_result_serializer
// Captures the flat result bus C on the single-cycle vin strobe from matrixMult
// and streams its rowsA*colsB elements, element 0 first, one per valid/ready
// handshake. This lets a stalling consumer sit behind matrixMult.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   vin        capture strobe; C is valid in this cycle
//   C          flat row-major matrix, element i at [(i+1)*dsize-1 -: dsize]
//   dout       current element (registered)
//   dvalid     dout holds a valid element
//   dready     consumer accepts when dvalid && dready
//   dlast      high with the final element
//   busy       a matrix is held or being sent
//   overrun    sticky: a vin arrived that could not be accepted
//   drow_last  (only with MATRIX_SER_ROW_MARK_EN) high with the last element
//              of each row
//
// Build option: define MATRIX_SER_ROW_MARK_EN to add the drow_last output.
// -----------------------------------------------------------------------------
module matrix_result_serializer
  import matrix_pkg::*;
#(
  parameter int dsize = DSIZE,
  parameter int rowsA = ROWS_A,
  parameter int colsB = COLS_B
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         vin,
  input  logic [rowsA*colsB*dsize-1:0] C,
  output logic [dsize-1:0]             dout,
  output logic                         dvalid,
  input  logic                         dready,
  output logic                         dlast,
  output logic                         busy,
  output logic                         overrun
`ifdef MATRIX_SER_ROW_MARK_EN
  ,
  output logic                         drow_last
`endif
);

  localparam int NE    = elem_count(rowsA, colsB);
  localparam int IDX_W = (NE > 1) ? $clog2(NE) : 1;
  localparam int CW    = NE * dsize;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NE - 1);

  ser_state_t        r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [CW-1:0]     r_shadow;
  logic [dsize-1:0]  r_dout;
  logic              r_dvalid;
  logic              r_dlast;
  logic              r_overrun;

  logic              w_hs;
  logic              w_at_last;
  logic              w_accept;
  logic [IDX_W-1:0]  w_idx_inc;

  function automatic logic [dsize-1:0] elem_sel(input logic [CW-1:0] m,
                                                input logic [IDX_W-1:0] i);
    return m[int'(i)*dsize +: dsize];
  endfunction

`ifdef MATRIX_SER_ROW_MARK_EN
  logic r_drow_last;

  function automatic logic row_end(input logic [IDX_W-1:0] i);
    return (int'(i) % colsB) == (colsB - 1);
  endfunction
`endif

  assign w_hs      = r_dvalid & dready;
  assign w_at_last = (r_idx == LAST_IDX);
  assign w_idx_inc = r_idx + IDX_W'(1);
  // A new matrix is taken when idle, or when the final element hands off in
  // the same cycle (back-to-back, no bubble).
  assign w_accept  = vin & ((r_state == IDLE) | (w_hs & w_at_last));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_shadow    <= '0;
      r_dout      <= '0;
      r_dvalid    <= 1'b0;
      r_dlast     <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef MATRIX_SER_ROW_MARK_EN
      r_drow_last <= 1'b0;
`endif
    end else if (w_accept) begin
      r_state     <= SEND;
      r_shadow    <= C;
      r_idx       <= '0;
      // Element 0 comes straight from C so it appears the cycle after vin.
      r_dout      <= elem_sel(C, '0);
      r_dvalid    <= 1'b1;
      r_dlast     <= (NE == 1);
`ifdef MATRIX_SER_ROW_MARK_EN
      r_drow_last <= row_end('0);
`endif
    end else begin
      case (r_state)
        IDLE: ;
        SEND: begin
          // Rejected capture: shadow is untouched, only the sticky flag moves.
          if (vin) r_overrun <= 1'b1;
          if (w_hs) begin
            if (w_at_last) begin
              r_state     <= IDLE;
              r_dvalid    <= 1'b0;
              r_dlast     <= 1'b0;
`ifdef MATRIX_SER_ROW_MARK_EN
              r_drow_last <= 1'b0;
`endif
            end else begin
              r_idx       <= w_idx_inc;
              r_dout      <= elem_sel(r_shadow, w_idx_inc);
              r_dlast     <= (w_idx_inc == LAST_IDX);
`ifdef MATRIX_SER_ROW_MARK_EN
              r_drow_last <= row_end(w_idx_inc);
`endif
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dout    = r_dout;
  assign dvalid  = r_dvalid;
  assign dlast   = r_dlast;
  assign busy    = (r_state == SEND);
  assign overrun = r_overrun;
`ifdef MATRIX_SER_ROW_MARK_EN
  assign drow_last = r_drow_last;
`endif

endmodule

// File: tb/tb_matrix_result_serializer.sv
// -----------------------------------------------------------------------------
// tb_matrix_result_serializer
// Self-checking bench for matrix_result_serializer (3x3, 8-bit elements).
// Expected elements are queued when a matrix is offered and popped on every
// handshake. Honors MATRIX_SER_ROW_MARK_EN for the drow_last output.
// -----------------------------------------------------------------------------
module tb_matrix_result_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vin = 1'b0;
  logic        dready = 1'b0;
  logic [71:0] C = '0;
  logic [7:0]  dout;
  logic        dvalid;
  logic        dlast;
  logic        busy;
  logic        overrun;
`ifdef MATRIX_SER_ROW_MARK_EN
  logic        drow_last;
`endif

  always #5 clk = ~clk;

  matrix_result_serializer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .vin      (vin),
    .C        (C),
    .dout     (dout),
    .dvalid   (dvalid),
    .dready   (dready),
    .dlast    (dlast),
    .busy     (busy),
    .overrun  (overrun)
`ifdef MATRIX_SER_ROW_MARK_EN
    ,
    .drow_last(drow_last)
`endif
  );

  typedef struct {
    logic [7:0] d;
    logic       last;
    logic       rlast;
  } exp_t;

  typedef struct {
    logic [71:0] c;
    int          mode;     // 0: ready high, 1: 1,0,0 pattern, 2: random
    logic        exp_ovr;
  } vec_t;

  localparam logic [71:0] MAT_A = 72'h090807060504030201;
  localparam logic [71:0] MAT_B = 72'h1211100F0E0D0C0B0A;
  localparam logic [71:0] MAT_C = 72'h807F00FF01FE55AA3C;
  localparam logic [71:0] MAT_F = {9{8'hFF}};

  exp_t exp_q[$];
  vec_t tbl[4];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  task automatic push_matrix(input logic [71:0] m);
    for (int i = 0; i < 9; i++) begin
      exp_t e;
      e.d     = m[i*8 +: 8];
      e.last  = (i == 8);
      e.rlast = ((i % 3) == 2);
      exp_q.push_back(e);
    end
  endtask

  // One clock: score a handshake if one is about to happen, and check that a
  // stalled element stays put across the edge.
  task automatic cycle();
    logic       hold;
    logic [7:0] hd;
    logic       hl;
    exp_t       e;
    hold = dvalid && !dready;
    hd   = dout;
    hl   = dlast;
    if (dvalid && dready) begin
      if (exp_q.size() == 0) begin
        chk("extra_elem", {64'd0, dout}, 72'h1FF);
      end else begin
        e = exp_q.pop_front();
        chk("dout", dout, e.d);
        chk("dlast", dlast, e.last);
`ifdef MATRIX_SER_ROW_MARK_EN
        chk("drow_last", drow_last, e.rlast);
`endif
      end
    end
    @(posedge clk);
    #1;
    if (hold) begin
      chk("stall_dout", dout, hd);
      chk("stall_dlast", dlast, hl);
    end
  endtask

  task automatic drain(input int mode);
    int budget;
    budget = 0;
    while ((exp_q.size() != 0 || dvalid) && budget < 200) begin
      case (mode)
        0:       dready = 1'b1;
        1:       dready = ((budget % 3) == 0);
        default: dready = 1'($urandom_range(0, 1));
      endcase
      cycle();
      budget++;
    end
    chk("drain_timeout", budget < 200, 1'b1);
    dready = 1'b1;
  endtask

  task automatic wait_elem(input logic [7:0] v);
    int b;
    b = 0;
    dready = 1'b1;
    while (!(dvalid && dout == v) && b < 50) begin
      cycle();
      b++;
    end
    chk("wait_elem_timeout", b < 50, 1'b1);
  endtask

  task automatic start(input logic [71:0] m);
    C   = m;
    vin = 1'b1;
    push_matrix(m);
    cycle();
    vin = 1'b0;
    C   = {9{8'hEE}};
  endtask

  task automatic apply_reset();
    rst_n  = 1'b0;
    vin    = 1'b0;
    dready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{c: MAT_A, mode: 0, exp_ovr: 1'b0};
    tbl[1] = '{c: MAT_A, mode: 1, exp_ovr: 1'b0};
    tbl[2] = '{c: MAT_C, mode: 2, exp_ovr: 1'b0};
    tbl[3] = '{c: MAT_B, mode: 0, exp_ovr: 1'b0};

    apply_reset();
    chk("rst_dout", dout, 8'h00);
    chk("rst_dvalid", dvalid, 1'b0);
    chk("rst_dlast", dlast, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overrun", overrun, 1'b0);

    // Table-driven single matrices.
    for (int i = 0; i < 4; i++) begin
      dready = 1'b1;
      start(tbl[i].c);
      chk("first_dvalid", dvalid, 1'b1);
      chk("first_busy", busy, 1'b1);
      chk("first_dout", dout, tbl[i].c[7:0]);
      drain(tbl[i].mode);
      chk("end_dvalid", dvalid, 1'b0);
      chk("end_busy", busy, 1'b0);
      chk("end_overrun", overrun, tbl[i].exp_ovr);
    end

    // Overrun: FF matrix offered mid-stream must be dropped.
    dready = 1'b1;
    start(MAT_A);
    wait_elem(8'h04);
    C   = MAT_F;
    vin = 1'b1;
    cycle();
    vin = 1'b0;
    C   = {9{8'hEE}};
    chk("ovr_set", overrun, 1'b1);
    drain(0);
    repeat (3) cycle();
    chk("ovr_idle_dvalid", dvalid, 1'b0);
    chk("ovr_sticky", overrun, 1'b1);
    apply_reset();
    chk("ovr_cleared", overrun, 1'b0);

    // Back-to-back: second vin coincident with the 09 handshake.
    dready = 1'b1;
    start(MAT_A);
    wait_elem(8'h09);
    chk("b2b_dlast", dlast, 1'b1);
    C   = MAT_B;
    vin = 1'b1;
    push_matrix(MAT_B);
    cycle();
    vin = 1'b0;
    C   = {9{8'hEE}};
    chk("b2b_dout", dout, 8'h0A);
    chk("b2b_dvalid", dvalid, 1'b1);
    chk("b2b_overrun", overrun, 1'b0);
    drain(0);
    chk("b2b_end_overrun", overrun, 1'b0);
    chk("b2b_end_busy", busy, 1'b0);

    // Async reset mid-stream.
    dready = 1'b1;
    start(MAT_A);
    wait_elem(8'h05);
    rst_n = 1'b0;
    #1;
    chk("arst_dout", dout, 8'h00);
    chk("arst_dvalid", dvalid, 1'b0);
    chk("arst_dlast", dlast, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_overrun", overrun, 1'b0);
`ifdef MATRIX_SER_ROW_MARK_EN
    chk("arst_drow_last", drow_last, 1'b0);
`endif
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_idle_dvalid", dvalid, 1'b0);
    start(MAT_A);
    chk("arst_restart_dout", dout, 8'h01);
    drain(1);
    chk("arst_end_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
